// File: rtl/gps_code_acq_if.sv
// Handshake and result bus for the C/A code phase acquisition block.
interface gps_code_acq_if;
    logic        ena_in;
    logic        start_in;
    logic [4:0]  n_sat_in;
    logic        signal_in;
    logic [10:0] threshold_in;
    logic        busy_out;
    logic        done_out;
    logic        found_out;
    logic [9:0]  phase_out;
    logic [10:0] peak_out;

    modport master (
        output ena_in, start_in, n_sat_in, signal_in, threshold_in,
        input  busy_out, done_out, found_out, phase_out, peak_out
    );

    modport slave (
        input  ena_in, start_in, n_sat_in, signal_in, threshold_in,
        output busy_out, done_out, found_out, phase_out, peak_out
    );
endinterface

// File: rtl/gps_code_acq.sv
// Serial-search C/A code phase acquisition: one 1023-chip dwell per candidate
// phase, one slipped strobe between dwells, best strict-greater peak wins.
module gps_code_acq #(
    parameter int unsigned N_PHASES = 1023
) (
    input  logic           clk_in,
    input  logic           rst_in_n,
    gps_code_acq_if.slave  bus
);
    localparam int unsigned CODE_LEN   = 1023;
    localparam logic [9:0]  LAST_CHIP  = 10'(CODE_LEN - 1);
    localparam logic [9:0]  LAST_PHASE = 10'(N_PHASES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DWELL, S_SLIP, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [9:0]  g1_q, g1_d, g2_q, g2_d;
    logic [4:0]  sat_q, sat_d;
    logic [10:0] thr_q, thr_d;
    logic [9:0]  chip_cnt_q, chip_cnt_d, phase_cnt_q, phase_cnt_d;
    logic [10:0] match_q, match_d, best_peak_q, best_peak_d;
    logic [9:0]  best_phase_q, best_phase_d;
    logic        busy_q, busy_d, done_q, done_d, found_q, found_d;
    logic [9:0]  phase_q, phase_d;
    logic [10:0] peak_q, peak_d;
    logic        chip_c, hit_c;
    logic [10:0] match_sum_c;

    // G2 phase-selector taps (stage numbers 1..10) as a bit mask
    function automatic logic [9:0] g2_mask(input logic [4:0] sat);
        logic [3:0] a, b;
        a = 4'd2; b = 4'd6;
        case (sat)
            5'd0:  begin a = 4'd2; b = 4'd6;  end
            5'd1:  begin a = 4'd3; b = 4'd7;  end
            5'd2:  begin a = 4'd4; b = 4'd8;  end
            5'd3:  begin a = 4'd5; b = 4'd9;  end
            5'd4:  begin a = 4'd1; b = 4'd9;  end
            5'd5:  begin a = 4'd2; b = 4'd10; end
            5'd6:  begin a = 4'd1; b = 4'd8;  end
            5'd7:  begin a = 4'd2; b = 4'd9;  end
            5'd8:  begin a = 4'd3; b = 4'd10; end
            5'd9:  begin a = 4'd2; b = 4'd3;  end
            5'd10: begin a = 4'd3; b = 4'd4;  end
            5'd11: begin a = 4'd5; b = 4'd6;  end
            5'd12: begin a = 4'd6; b = 4'd7;  end
            5'd13: begin a = 4'd7; b = 4'd8;  end
            5'd14: begin a = 4'd8; b = 4'd9;  end
            5'd15: begin a = 4'd9; b = 4'd10; end
            5'd16: begin a = 4'd1; b = 4'd4;  end
            5'd17: begin a = 4'd2; b = 4'd5;  end
            5'd18: begin a = 4'd3; b = 4'd6;  end
            5'd19: begin a = 4'd4; b = 4'd7;  end
            5'd20: begin a = 4'd5; b = 4'd8;  end
            5'd21: begin a = 4'd6; b = 4'd9;  end
            5'd22: begin a = 4'd1; b = 4'd3;  end
            5'd23: begin a = 4'd4; b = 4'd6;  end
            5'd24: begin a = 4'd5; b = 4'd7;  end
            5'd25: begin a = 4'd6; b = 4'd8;  end
            5'd26: begin a = 4'd7; b = 4'd9;  end
            5'd27: begin a = 4'd8; b = 4'd10; end
            5'd28: begin a = 4'd1; b = 4'd6;  end
            5'd29: begin a = 4'd2; b = 4'd7;  end
            5'd30: begin a = 4'd3; b = 4'd8;  end
            5'd31: begin a = 4'd4; b = 4'd9;  end
            default: begin a = 4'd2; b = 4'd6; end
        endcase
        return (10'd1 << (a - 4'd1)) | (10'd1 << (b - 4'd1));
    endfunction

    assign chip_c      = g1_q[9] ^ (^(g2_q & g2_mask(sat_q)));
    assign hit_c       = (bus.signal_in == chip_c);
    assign match_sum_c = match_q + 11'(hit_c);

    always_comb begin
        state_d      = state_q;
        g1_d         = g1_q;
        g2_d         = g2_q;
        sat_d        = sat_q;
        thr_d        = thr_q;
        chip_cnt_d   = chip_cnt_q;
        phase_cnt_d  = phase_cnt_q;
        match_d      = match_q;
        best_peak_d  = best_peak_q;
        best_phase_d = best_phase_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        found_d      = found_q;
        phase_d      = phase_q;
        peak_d       = peak_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_in) begin
                    g1_d         = '1;
                    g2_d         = '1;
                    sat_d        = bus.n_sat_in;
                    thr_d        = bus.threshold_in;
                    chip_cnt_d   = '0;
                    phase_cnt_d  = '0;
                    match_d      = '0;
                    best_peak_d  = '0;
                    best_phase_d = '0;
                    busy_d       = 1'b1;
                    state_d      = S_DWELL;
                end
            end
            S_DWELL: begin
                if (bus.ena_in) begin
                    g1_d = {g1_q[8:0], g1_q[2] ^ g1_q[9]};
                    g2_d = {g2_q[8:0], g2_q[1] ^ g2_q[2] ^ g2_q[5] ^ g2_q[7] ^ g2_q[8] ^ g2_q[9]};
                    if (chip_cnt_q == LAST_CHIP) begin
                        chip_cnt_d = '0;
                        match_d    = '0;
                        if (match_sum_c > best_peak_q) begin
                            best_peak_d  = match_sum_c;
                            best_phase_d = phase_cnt_q;
                        end
                        if (phase_cnt_q == LAST_PHASE) begin
                            // Results publish on the same edge that enters DONE
                            phase_d = best_phase_d;
                            peak_d  = best_peak_d;
                            found_d = (best_peak_d >= thr_q);
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_DONE;
                        end else begin
                            phase_cnt_d = phase_cnt_q + 10'd1;
                            state_d     = S_SLIP;
                        end
                    end else begin
                        chip_cnt_d = chip_cnt_q + 10'd1;
                        match_d    = match_sum_c;
                    end
                end
            end
            S_SLIP: begin
                if (bus.ena_in) state_d = S_DWELL;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q      <= S_IDLE;
            g1_q         <= '0;
            g2_q         <= '0;
            sat_q        <= '0;
            thr_q        <= '0;
            chip_cnt_q   <= '0;
            phase_cnt_q  <= '0;
            match_q      <= '0;
            best_peak_q  <= '0;
            best_phase_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
            phase_q      <= '0;
            peak_q       <= '0;
        end else begin
            state_q      <= state_d;
            g1_q         <= g1_d;
            g2_q         <= g2_d;
            sat_q        <= sat_d;
            thr_q        <= thr_d;
            chip_cnt_q   <= chip_cnt_d;
            phase_cnt_q  <= phase_cnt_d;
            match_q      <= match_d;
            best_peak_q  <= best_peak_d;
            best_phase_q <= best_phase_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            found_q      <= found_d;
            phase_q      <= phase_d;
            peak_q       <= peak_d;
        end
    end

    assign bus.busy_out  = busy_q;
    assign bus.done_out  = done_q;
    assign bus.found_out = found_q;
    assign bus.phase_out = phase_q;
    assign bus.peak_out  = peak_q;
endmodule

// File: tb/tb_gps_code_acq.sv
// Bench for gps_code_acq: Gold-code sequence reference, directed searches with
// random satellites, strobe gaps, noise, ignored starts and an async abort.
module tb_gps_code_acq;
    localparam int NP       = 8;
    localparam int CODE_LEN = 1023;
    localparam int TOTAL    = CODE_LEN * NP + NP - 1;

    logic clk_in   = 1'b0;
    logic rst_in_n = 1'b0;
    always #5 clk_in = ~clk_in;

    gps_code_acq_if bus ();
    gps_code_acq #(.N_PHASES(NP)) dut (.clk_in(clk_in), .rst_in_n(rst_in_n), .bus(bus));

    int checks   = 0;
    int failures = 0;
    bit code_c [0:CODE_LEN-1];
    bit sigs   [0:TOTAL-1];
    int tap_a [0:31] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int tap_b [0:31] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};
    int exp_phase, exp_peak, exp_found;

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // C/A code from the G1/G2 output-sequence recurrences (all-ones seed)
    task automatic build_code(input int sat);
        bit a [0:1039];
        bit h [0:1039];
        for (int i = 0; i < 10; i++) begin a[i] = 1'b1; h[i] = 1'b1; end
        for (int i = 10; i < 1040; i++) begin
            a[i] = a[i-3] ^ a[i-10];
            h[i] = h[i-2] ^ h[i-3] ^ h[i-6] ^ h[i-8] ^ h[i-9] ^ h[i-10];
        end
        for (int n = 0; n < CODE_LEN; n++)
            code_c[n] = a[n] ^ h[n + 10 - tap_a[sat]] ^ h[n + 10 - tap_b[sat]];
    endtask

    function automatic bit gen_sig(input int mode, input int delay, input int j);
        bit s;
        s = code_c[((j - delay) % CODE_LEN + CODE_LEN) % CODE_LEN];
        case (mode)
            0: gen_sig = s;
            1: gen_sig = 1'b0;
            default: gen_sig = ($urandom_range(99) < 25) ? ~s : s;
        endcase
    endfunction

    // Expected result: phase k scores strobes k*1024 .. k*1024+1022 against C[0..1022]
    task automatic model(input int thr);
        int score;
        exp_peak  = 0;
        exp_phase = 0;
        for (int k = 0; k < NP; k++) begin
            score = 0;
            for (int i = 0; i < CODE_LEN; i++)
                if (sigs[k*1024 + i] == code_c[i]) score++;
            if (score > exp_peak) begin exp_peak = score; exp_phase = k; end
        end
        exp_found = (exp_peak >= thr) ? 1 : 0;
    endtask

    task automatic run_search(input string name, input int sat, input int mode, input int delay,
                              input int duty, input int thr, input bit mid_start, input int abort_at);
        int  j, cycles;
        bit  busy_ok, e;
        build_code(sat);
        @(negedge clk_in);
        bus.n_sat_in     = 5'(sat);
        bus.threshold_in = 11'(thr);
        bus.start_in     = 1'b1;
        bus.ena_in       = 1'b1;
        bus.signal_in    = 1'($urandom_range(1));
        @(negedge clk_in);
        bus.start_in = 1'b0;
        busy_ok = 1'b1;
        j = 0;
        cycles = 0;
        while (j < TOTAL) begin
            if (bus.busy_out !== 1'b1 || bus.done_out !== 1'b0) busy_ok = 1'b0;
            if (j == abort_at) begin
                #3 rst_in_n = 1'b0;
                #1;
                check({name, "_abort_busy"},  int'(bus.busy_out),  0);
                check({name, "_abort_done"},  int'(bus.done_out),  0);
                check({name, "_abort_found"}, int'(bus.found_out), 0);
                check({name, "_abort_phase"}, int'(bus.phase_out), 0);
                check({name, "_abort_peak"},  int'(bus.peak_out),  0);
                bus.ena_in   = 1'b0;
                bus.start_in = 1'b0;
                @(negedge clk_in);
                rst_in_n = 1'b1;
                @(negedge clk_in);
                check({name, "_abort_idle"}, int'(bus.busy_out), 0);
                return;
            end
            if (cycles > TOTAL * 10) begin
                check({name, "_timeout"}, j, TOTAL);
                return;
            end
            e = ($urandom_range(99) < duty);
            bus.start_in = mid_start && (j == 3000);
            bus.ena_in   = e;
            if (e) begin
                sigs[j]       = gen_sig(mode, delay, j);
                bus.signal_in = sigs[j];
                j++;
            end else begin
                bus.signal_in = 1'($urandom_range(1));
            end
            cycles++;
            @(negedge clk_in);
        end
        model(thr);
        check({name, "_busy_during"}, int'(busy_ok), 1);
        check({name, "_done"},  int'(bus.done_out),  1);
        check({name, "_busy_at_done"}, int'(bus.busy_out), 0);
        check({name, "_phase"}, int'(bus.phase_out), exp_phase);
        check({name, "_peak"},  int'(bus.peak_out),  exp_peak);
        check({name, "_found"}, int'(bus.found_out), exp_found);
        bus.start_in = 1'b1;
        bus.ena_in   = 1'($urandom_range(1));
        @(negedge clk_in);
        bus.start_in = 1'b0;
        bus.ena_in   = 1'b0;
        check({name, "_done_width"}, int'(bus.done_out), 0);
        check({name, "_start_in_done_ignored"}, int'(bus.busy_out), 0);
        check({name, "_phase_hold"}, int'(bus.phase_out), exp_phase);
    endtask

    initial begin
        int sat, dly;
        bus.ena_in       = 1'b0;
        bus.start_in     = 1'b0;
        bus.n_sat_in     = '0;
        bus.signal_in    = 1'b0;
        bus.threshold_in = '0;
        #12;
        check("rst_busy",  int'(bus.busy_out),  0);
        check("rst_done",  int'(bus.done_out),  0);
        check("rst_found", int'(bus.found_out), 0);
        check("rst_phase", int'(bus.phase_out), 0);
        check("rst_peak",  int'(bus.peak_out),  0);
        @(negedge clk_in);
        rst_in_n = 1'b1;

        run_search("prn3_d5", 2, 0, 5, 100, 900, 1'b1, -1);
        check("prn3_d5_const_phase", int'(bus.phase_out), 5);
        check("prn3_d5_const_peak",  int'(bus.peak_out),  1023);
        check("prn3_d5_const_found", int'(bus.found_out), 1);

        run_search("prn3_d2", 2, 0, 2, 100, 900, 1'b0, -1);
        check("prn3_d2_const_phase", int'(bus.phase_out), 2);

        sat = $urandom_range(31);
        run_search("zeros", sat, 1, 0, 100, 800, 1'b0, -1);
        check("zeros_const_phase", int'(bus.phase_out), 0);
        check("zeros_const_peak",  int'(bus.peak_out),  511);
        check("zeros_const_found", int'(bus.found_out), 0);

        run_search("prn5_gaps", 4, 0, 6, 30, 900, 1'b1, -1);
        check("prn5_gaps_const_phase", int'(bus.phase_out), 6);
        check("prn5_gaps_const_peak",  int'(bus.peak_out),  1023);

        sat = $urandom_range(31);
        dly = $urandom_range(1, 7);
        run_search("noisy", sat, 2, dly, 100, 700, 1'b0, -1);

        sat = $urandom_range(31);
        run_search("aborted", sat, 0, 3, 100, 900, 1'b0, 2500);

        sat = $urandom_range(31);
        dly = $urandom_range(0, 7);
        run_search("after_abort", sat, 0, dly, 100, 900, 1'b0, -1);
        check("after_abort_const_phase", int'(bus.phase_out), dly);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
